btn_event_decoder: RTL

// - Consumes the clean level from the button debouncer and classifies it into single-cycle events.
// - Events: press, release, short press, long press and (optional) auto-repeat.
// - Sits between the debouncer output and the FSMs/counters driven by lab pushbuttons.
// - One decoder instance per button.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/edge_detect.sv | 22 ++
 rtl/btn_event_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton event decoder.
package btn_pkg;

  localparam int unsigned LONG_CYCLES_DEF   = 100_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 20_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_e;

  // One bit per single-cycle event, for consumers that want them as a bundle
  typedef struct packed {
    logic press;
    logic rel;
    logic short_p;
    logic long_p;
    logic rpt;
  } btn_events_t;

  function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered copy of a synchronous level plus rise/fall strobes against it.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/release/short/long/repeat pulses.
// Auto-repeat in LONG_HELD is built only when AUTO_REPEAT_EN is defined.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic db_in,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(cyc_max(LONG_CYCLES, REPEAT_CYCLES)) + 1;

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_chk
    $error("btn_event_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_events_t      ev_q, ev_d;
  logic             held_q;
  logic             rise, fall;

  // Reset value 1 so a button already held at reset needs a fresh press
  edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (db_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ev_q    <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      held_q  <= (state_d != IDLE);
    end
  end

  // In PRESSED/LONG_HELD the registered level is always 1, so fall == ~db_in there
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = '0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d  = PRESSED;
            cnt_d    = '0;
            ev_d.press = 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_d      = IDLE;
            cnt_d        = '0;
            ev_d.rel     = 1'b1;
            ev_d.short_p = 1'b1;
          end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
            state_d     = LONG_HELD;
            cnt_d       = '0;
            ev_d.long_p = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_d  = IDLE;
            cnt_d    = '0;
            ev_d.rel = 1'b1;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
              cnt_d    = '0;
              ev_d.rpt = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign press_pulse   = ev_q.press;
  assign release_pulse = ev_q.rel;
  assign short_press   = ev_q.short_p;
  assign long_press    = ev_q.long_p;
  assign repeat_pulse  = ev_q.rpt;
  assign held          = held_q;

endmodule
